// File: rtl/pipe_stage_regs.sv
// Pipeline front-end state: fetch PC, IF/ID and ID/EX registers, driven by the
// hazard unit's stall/flush controls, plus saturating stall/flush counters.
module pipe_stage_regs #(
  parameter int unsigned          XLEN     = 32,
  parameter logic [XLEN-1:0]      RESET_PC = '0,
  parameter int unsigned          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             FlushE,
  input  logic             PCSrcE,
  input  logic [XLEN-1:0]  PCTargetE,
  input  logic [31:0]      InstrF,
  output logic [XLEN-1:0]  PCF,
  output logic [31:0]      InstrD,
  output logic [XLEN-1:0]  PCD,
  output logic [XLEN-1:0]  PCPlus4D,
  output logic             validD,
  input  logic             RegWEnD,
  input  logic             MemWEnD,
  input  logic             BranchD,
  input  logic             JumpD,
  input  logic [1:0]       DdataSelD,
  input  logic [3:0]       ALUCtrlD,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rdD,
  input  logic [XLEN-1:0]  RD1D,
  input  logic [XLEN-1:0]  RD2D,
  input  logic [XLEN-1:0]  ImmExtD,
  output logic             RegWEnE,
  output logic             MemWEnE,
  output logic             BranchE,
  output logic             JumpE,
  output logic [1:0]       DdataSelE,
  output logic [3:0]       ALUCtrlE,
  output logic [4:0]       rs1E,
  output logic [4:0]       rs2E,
  output logic [4:0]       rdE,
  output logic [XLEN-1:0]  RD1E,
  output logic [XLEN-1:0]  RD2E,
  output logic [XLEN-1:0]  ImmExtE,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  PCPlus4E,
  output logic             validE,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  // Bubble writeback select is non-zero so a bubble never looks like a load.
  localparam logic [1:0]  BUB_DSEL  = 2'b01;

  logic [XLEN-1:0]  pcf_q, pcf_d, pc_plus4f;
  logic [31:0]      instrd_q, instrd_d;
  logic [XLEN-1:0]  pcd_q, pcd_d, pc4d_q, pc4d_d;
  logic             validd_q, validd_d;
  logic             regwen_q, regwen_d, memwen_q, memwen_d;
  logic             branch_q, branch_d, jump_q, jump_d;
  logic [1:0]       dsel_q, dsel_d;
  logic [3:0]       aluctrl_q, aluctrl_d;
  logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [XLEN-1:0]  rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [XLEN-1:0]  pce_q, pce_d, pc4e_q, pc4e_d;
  logic             valide_q, valide_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  assign pc_plus4f = pcf_q + XLEN'(4);

  // Next-state selection for PC, IF/ID, ID/EX and the event counters.
  always_comb begin
    pcf_d = pcf_q;
    if (!StallF) pcf_d = PCSrcE ? PCTargetE : pc_plus4f;

    instrd_d = instrd_q;
    pcd_d    = pcd_q;
    pc4d_d   = pc4d_q;
    validd_d = validd_q;
    if (FlushD) begin
      instrd_d = NOP_INSTR;
      pcd_d    = '0;
      pc4d_d   = '0;
      validd_d = 1'b0;
    end else if (!StallD) begin
      instrd_d = InstrF;
      pcd_d    = pcf_q;
      pc4d_d   = pc_plus4f;
      validd_d = 1'b1;
    end

    if (FlushE) begin
      regwen_d  = 1'b0;
      memwen_d  = 1'b0;
      branch_d  = 1'b0;
      jump_d    = 1'b0;
      dsel_d    = BUB_DSEL;
      aluctrl_d = '0;
      rs1_d     = '0;
      rs2_d     = '0;
      rd_d      = '0;
      rd1_d     = '0;
      rd2_d     = '0;
      imm_d     = '0;
      pce_d     = '0;
      pc4e_d    = '0;
      valide_d  = 1'b0;
    end else begin
      regwen_d  = RegWEnD;
      memwen_d  = MemWEnD;
      branch_d  = BranchD;
      jump_d    = JumpD;
      dsel_d    = DdataSelD;
      aluctrl_d = ALUCtrlD;
      rs1_d     = rs1D;
      rs2_d     = rs2D;
      rd_d      = rdD;
      rd1_d     = RD1D;
      rd2_d     = RD2D;
      imm_d     = ImmExtD;
      pce_d     = pcd_q;
      pc4e_d    = pc4d_q;
      valide_d  = validd_q;
    end

    stall_cnt_d = stall_cnt_q;
    if (StallF && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    flush_cnt_d = flush_cnt_q;
    if (FlushD && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // State registers; reset loads RESET_PC and bubbles both stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcf_q       <= RESET_PC;
      instrd_q    <= NOP_INSTR;
      pcd_q       <= '0;
      pc4d_q      <= '0;
      validd_q    <= 1'b0;
      regwen_q    <= 1'b0;
      memwen_q    <= 1'b0;
      branch_q    <= 1'b0;
      jump_q      <= 1'b0;
      dsel_q      <= BUB_DSEL;
      aluctrl_q   <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      pce_q       <= '0;
      pc4e_q      <= '0;
      valide_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pcf_q       <= pcf_d;
      instrd_q    <= instrd_d;
      pcd_q       <= pcd_d;
      pc4d_q      <= pc4d_d;
      validd_q    <= validd_d;
      regwen_q    <= regwen_d;
      memwen_q    <= memwen_d;
      branch_q    <= branch_d;
      jump_q      <= jump_d;
      dsel_q      <= dsel_d;
      aluctrl_q   <= aluctrl_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      imm_q       <= imm_d;
      pce_q       <= pce_d;
      pc4e_q      <= pc4e_d;
      valide_q    <= valide_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign PCF       = pcf_q;
  assign InstrD    = instrd_q;
  assign PCD       = pcd_q;
  assign PCPlus4D  = pc4d_q;
  assign validD    = validd_q;
  assign RegWEnE   = regwen_q;
  assign MemWEnE   = memwen_q;
  assign BranchE   = branch_q;
  assign JumpE     = jump_q;
  assign DdataSelE = dsel_q;
  assign ALUCtrlE  = aluctrl_q;
  assign rs1E      = rs1_q;
  assign rs2E      = rs2_q;
  assign rdE       = rd_q;
  assign RD1E      = rd1_q;
  assign RD2E      = rd2_q;
  assign ImmExtE   = imm_q;
  assign PCE       = pce_q;
  assign PCPlus4E  = pc4e_q;
  assign validE    = valide_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Bench for pipe_stage_regs: directed scenarios plus a random hazard run,
// all checked against a cycle-level behavioural model of the three stages.
module tb_pipe_stage_regs;

  localparam int E_W = 185;
  localparam logic [E_W-1:0] E_BUB = {4'b0000, 2'b01, 179'b0};

  logic clk = 1'b0;
  logic rst, StallF, StallD, FlushD, FlushE, PCSrcE;
  logic [31:0] PCTargetE, InstrF;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic validD;
  logic RegWEnD, MemWEnD, BranchD, JumpD;
  logic [1:0] DdataSelD;
  logic [3:0] ALUCtrlD;
  logic [4:0] rs1D, rs2D, rdD;
  logic [31:0] RD1D, RD2D, ImmExtD;
  logic RegWEnE, MemWEnE, BranchE, JumpE;
  logic [1:0] DdataSelE;
  logic [3:0] ALUCtrlE;
  logic [4:0] rs1E, rs2E, rdE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic validE;
  logic [3:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_instrD, m_pcD, m_pc4D;
  logic        m_vD, m_vE;
  logic [E_W-1:0] m_e;
  int m_sc, m_fc;

  always #5 clk = ~clk;

  pipe_stage_regs #(.XLEN(32), .RESET_PC(32'h0000_0000), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .FlushE(FlushE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .InstrF(InstrF),
    .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .validD(validD),
    .RegWEnD(RegWEnD), .MemWEnD(MemWEnD), .BranchD(BranchD), .JumpD(JumpD),
    .DdataSelD(DdataSelD), .ALUCtrlD(ALUCtrlD), .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
    .RegWEnE(RegWEnE), .MemWEnE(MemWEnE), .BranchE(BranchE), .JumpE(JumpE),
    .DdataSelE(DdataSelE), .ALUCtrlE(ALUCtrlE), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .validE(validE), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic logic [31:0] imem(input logic [31:0] pc);
    return (pc * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [322:0] dut_vec();
    return {PCF, InstrD, PCD, PCPlus4D, validD,
            RegWEnE, MemWEnE, BranchE, JumpE, DdataSelE, ALUCtrlE, rs1E, rs2E, rdE,
            RD1E, RD2E, ImmExtE, PCE, PCPlus4E, validE, stall_cnt, flush_cnt};
  endfunction

  function automatic logic [322:0] mdl_vec();
    logic [3:0] sc, fc;
    sc = 4'(m_sc);
    fc = 4'(m_fc);
    return {m_pc, m_instrD, m_pcD, m_pc4D, m_vD, m_e, m_vE, sc, fc};
  endfunction

  // One clock: randomise decoded inputs, fetch from the model PC, advance model.
  task automatic tick();
    logic [E_W-1:0] e_in;
    RegWEnD   = 1'($urandom);
    MemWEnD   = 1'($urandom);
    BranchD   = 1'($urandom);
    JumpD     = 1'($urandom);
    DdataSelD = 2'($urandom);
    ALUCtrlD  = 4'($urandom);
    rs1D      = 5'($urandom);
    rs2D      = 5'($urandom);
    rdD       = 5'($urandom);
    RD1D      = $urandom;
    RD2D      = $urandom;
    ImmExtD   = $urandom;
    InstrF    = imem(m_pc);
    @(posedge clk);
    if (rst) begin
      m_pc = 32'h0; m_instrD = 32'h13; m_pcD = 0; m_pc4D = 0; m_vD = 0;
      m_e = E_BUB; m_vE = 0; m_sc = 0; m_fc = 0;
    end else begin
      e_in = {RegWEnD, MemWEnD, BranchD, JumpD, DdataSelD, ALUCtrlD, rs1D, rs2D, rdD,
              RD1D, RD2D, ImmExtD, m_pcD, m_pc4D};
      if (FlushE) begin m_e = E_BUB; m_vE = 0; end
      else begin m_e = e_in; m_vE = m_vD; end
      if (FlushD) begin
        m_instrD = 32'h13; m_pcD = 0; m_pc4D = 0; m_vD = 0;
      end else if (!StallD) begin
        m_instrD = imem(m_pc); m_pcD = m_pc; m_pc4D = m_pc + 4; m_vD = 1;
      end
      if (StallF && m_sc < 15) m_sc++;
      if (FlushD && m_fc < 15) m_fc++;
      if (!StallF) m_pc = PCSrcE ? PCTargetE : m_pc + 4;
    end
    #1;
  endtask

  task automatic clear_hz();
    StallF = 0; StallD = 0; FlushD = 0; FlushE = 0; PCSrcE = 0; PCTargetE = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_hz();
    tick(); tick();
    checks++; if (dut_vec() !== mdl_vec()) begin errors++;
      $display("FAIL reset_state got %h exp %h", dut_vec(), mdl_vec()); end
    checks++; if (PCF !== 32'h0) begin errors++;
      $display("FAIL reset_pcf got %h exp 00000000", PCF); end
    checks++; if ({DdataSelE, validD, validE, stall_cnt, flush_cnt} !== {2'b01, 2'b00, 8'h00}) begin errors++;
      $display("FAIL reset_bubble got dsel=%b vD=%b vE=%b sc=%h fc=%h", DdataSelE, validD, validE, stall_cnt, flush_cnt); end
  endtask

  task automatic test_free_run();
    logic [31:0] exp_pc;
    rst = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      exp_pc = 32'(4 * i);
      checks++; if (PCF !== exp_pc) begin errors++;
        $display("FAIL free_run_pcf got %h exp %h", PCF, exp_pc); end
      checks++; if (dut_vec() !== mdl_vec()) begin errors++;
        $display("FAIL free_run_state got %h exp %h", dut_vec(), mdl_vec()); end
    end
    checks++; if (InstrD !== imem(32'hC) || validD !== 1'b1) begin errors++;
      $display("FAIL free_run_instrd got %h/%b exp %h/1", InstrD, validD, imem(32'hC)); end
  endtask

  task automatic test_load_use();
    StallF = 1; StallD = 1; FlushE = 1;
    tick();
    clear_hz();
    checks++; if (PCF !== 32'h10 || InstrD !== imem(32'hC)) begin errors++;
      $display("FAIL load_use_hold got pc=%h instr=%h exp pc=00000010 instr=%h", PCF, InstrD, imem(32'hC)); end
    checks++; if (validE !== 1'b0 || rdE !== 5'd0 || DdataSelE !== 2'b01) begin errors++;
      $display("FAIL load_use_bubble got vE=%b rd=%h dsel=%b exp 0/00/01", validE, rdE, DdataSelE); end
    checks++; if (stall_cnt !== 4'd1) begin errors++;
      $display("FAIL load_use_cnt got %h exp 1", stall_cnt); end
    checks++; if (dut_vec() !== mdl_vec()) begin errors++;
      $display("FAIL load_use_state got %h exp %h", dut_vec(), mdl_vec()); end
    tick();
    checks++; if (PCF !== 32'h14 || PCE !== 32'hC || validE !== 1'b1) begin errors++;
      $display("FAIL load_use_release got pc=%h pce=%h vE=%b exp 00000014/0000000c/1", PCF, PCE, validE); end
  endtask

  task automatic test_branch();
    int n = 0;
    while (m_pc != 32'h20 && n < 10) begin tick(); n++; end
    checks++; if (PCF !== 32'h20) begin errors++;
      $display("FAIL branch_setup got %h exp 00000020", PCF); end
    PCSrcE = 1; PCTargetE = 32'h100; FlushD = 1; FlushE = 1;
    tick();
    clear_hz();
    checks++; if (PCF !== 32'h100) begin errors++;
      $display("FAIL branch_pcf got %h exp 00000100", PCF); end
    checks++; if (InstrD !== 32'h13 || validD !== 1'b0 || validE !== 1'b0) begin errors++;
      $display("FAIL branch_flush got instr=%h vD=%b vE=%b exp 00000013/0/0", InstrD, validD, validE); end
    checks++; if (flush_cnt !== 4'd1) begin errors++;
      $display("FAIL branch_cnt got %h exp 1", flush_cnt); end
  endtask

  task automatic test_flush_vs_stall();
    logic [31:0] held;
    StallD = 1; FlushD = 1;
    tick();
    clear_hz();
    checks++; if (InstrD !== 32'h13 || validD !== 1'b0 || PCD !== 32'h0) begin errors++;
      $display("FAIL flush_over_stall got instr=%h vD=%b pcd=%h exp 00000013/0/0", InstrD, validD, PCD); end
    held = PCF;
    StallF = 1; PCSrcE = 1; PCTargetE = 32'h200;
    tick();
    clear_hz();
    checks++; if (PCF !== 32'h104 || PCF !== held) begin errors++;
      $display("FAIL stall_over_redirect got %h exp 00000104", PCF); end
    checks++; if (dut_vec() !== mdl_vec()) begin errors++;
      $display("FAIL flush_vs_stall_state got %h exp %h", dut_vec(), mdl_vec()); end
  endtask

  task automatic test_wrap();
    PCSrcE = 1; PCTargetE = 32'hFFFF_FFF8;
    tick();
    clear_hz();
    tick();
    checks++; if (PCF !== 32'hFFFF_FFFC) begin errors++;
      $display("FAIL wrap_pre got %h exp fffffffc", PCF); end
    tick();
    checks++; if (PCF !== 32'h0) begin errors++;
      $display("FAIL wrap_pcf got %h exp 00000000", PCF); end
    checks++; if (PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0) begin errors++;
      $display("FAIL wrap_pcplus4 got pcd=%h pc4=%h exp fffffffc/00000000", PCD, PCPlus4D); end
  endtask

  task automatic test_saturation();
    StallF = 1; StallD = 1;
    for (int i = 0; i < 20; i++) tick();
    checks++; if (stall_cnt !== 4'hF) begin errors++;
      $display("FAIL stall_saturate got %h exp f", stall_cnt); end
    checks++; if (dut_vec() !== mdl_vec()) begin errors++;
      $display("FAIL saturate_state got %h exp %h", dut_vec(), mdl_vec()); end
  endtask

  task automatic test_reset_mid_stall();
    StallF = 1; StallD = 1; FlushD = 1; rst = 1;
    tick();
    checks++; if (PCF !== 32'h0 || stall_cnt !== 4'h0 || flush_cnt !== 4'h0) begin errors++;
      $display("FAIL rst_mid_stall got pc=%h sc=%h fc=%h exp 0/0/0", PCF, stall_cnt, flush_cnt); end
    checks++; if (validD !== 1'b0 || validE !== 1'b0 || InstrD !== 32'h13 || DdataSelE !== 2'b01) begin errors++;
      $display("FAIL rst_mid_bubble got vD=%b vE=%b instr=%h dsel=%b", validD, validE, InstrD, DdataSelE); end
    rst = 0; clear_hz();
    tick();
    checks++; if (PCF !== 32'h4 || InstrD !== imem(32'h0) || PCD !== 32'h0) begin errors++;
      $display("FAIL rst_first_fetch got pc=%h instr=%h pcd=%h exp 00000004/%h/0", PCF, InstrD, PCD, imem(32'h0)); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 39) == 0);
      StallF    = ($urandom_range(0, 3) == 0);
      StallD    = StallF ? 1'b1 : ($urandom_range(0, 7) == 0);
      FlushD    = ($urandom_range(0, 5) == 0);
      FlushE    = ($urandom_range(0, 4) == 0);
      PCSrcE    = ($urandom_range(0, 5) == 0);
      PCTargetE = $urandom & 32'hFFFF_FFFC;
      tick();
      checks++; if (dut_vec() !== mdl_vec()) begin errors++;
        $display("FAIL random_cycle_%0d got %h exp %h", i, dut_vec(), mdl_vec()); end
    end
    rst = 0; clear_hz();
  endtask

  initial begin
    m_pc = 0; m_instrD = 32'h13; m_pcD = 0; m_pc4D = 0; m_vD = 0;
    m_e = E_BUB; m_vE = 0; m_sc = 0; m_fc = 0;
    test_reset();
    test_free_run();
    test_load_use();
    test_branch();
    test_flush_vs_stall();
    test_wrap();
    test_saturation();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_regs.md
# pipe_stage_regs

Sequential responder to the hazard unit's stall/flush outputs in the 5-stage RISC-V pipeline. Holds the fetch PC register, the IF/ID register and the ID/EX register. Applies StallF, StallD, FlushD and FlushE to those registers, inserting NOP bubbles on flush and holding state on stall. Also keeps saturating stall and flush event counters for performance debug.

## Interface

Parameters:
- XLEN, 32, datapath/PC width
- RESET_PC, 32'h0000_0000, PCF value after reset
- CNT_W, 32, width of the event counters

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- StallF  in  1  hold the PC register
- StallD  in  1  hold the IF/ID register
- FlushD  in  1  bubble the IF/ID register
- FlushE  in  1  bubble the ID/EX register
- PCSrcE  in  1  redirect fetch to PCTargetE
- PCTargetE  in  XLEN  branch/jump target
- InstrF  in  32  instruction-memory read data for PCF
- PCF  out  XLEN  current fetch PC
- InstrD, PCD, PCPlus4D  out  32/XLEN/XLEN  IF/ID contents
- validD  out  1  IF/ID holds a real instruction
- RegWEnD, MemWEnD, BranchD, JumpD  in  1 each  decoded controls
- DdataSelD  in  2  writeback select (2'b00 = load data)
- ALUCtrlD  in  4  ALU operation
- rs1D, rs2D, rdD  in  5 each  register indices
- RD1D, RD2D, ImmExtD  in  XLEN each  operands and immediate
- RegWEnE, MemWEnE, BranchE, JumpE, DdataSelE, ALUCtrlE, rs1E, rs2E, rdE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  same widths  ID/EX contents
- validE  out  1  ID/EX holds a real instruction
- stall_cnt  out  CNT_W  cycles with StallF=1
- flush_cnt  out  CNT_W  cycles with FlushD=1

## Operation

- PC register priority: rst > StallF > PCSrcE > sequential. Redirect loads PCTargetE; otherwise PCF <= PCF+4, modulo 2^XLEN, wrapping at the top of the address space.
- PCSrcE arriving together with StallF is ignored. The hazard unit guarantees these are exclusive.
- IF/ID priority: rst or FlushD > StallD > load.
  - Load: InstrD<=InstrF, PCD<=PCF, PCPlus4D<=PCF+4, validD<=1.
  - Flush wins over a simultaneous StallD.
- IF/ID bubble: InstrD=32'h0000_0013 (addi x0,x0,0), PCD=0, PCPlus4D=0, validD=0.
- ID/EX priority: rst or FlushE > load. There is no ID/EX stall. Load copies every *D input to its *E output, and validE<=validD.
- ID/EX bubble: all controls 0 (RegWEnE, MemWEnE, BranchE, JumpE), ALUCtrlE=0, rs1E=rs2E=rdE=0, all data fields 0, validE=0.
  - DdataSelE=2'b01 in the bubble, never 2'b00, so the hazard unit never sees a phantom load.
- Counters increment by 1 per cycle with the qualifying input high, saturate at all-ones and do not wrap. rst clears both.

## Timing

- All state updates on the rising clk edge. Outputs come straight from registers, with no combinational input-to-output paths.
- Reset values (rst high at an edge): PCF=RESET_PC. IF/ID and ID/EX hold bubble values, validD=validE=0, counters=0. Takes effect at that same edge, and rst overrides every other input.
- Latency:
  - Word fetched at PCF in cycle n appears on InstrD in n+1 and on the *E outputs in n+2, if not stalled or flushed.
  - A redirect (PCSrcE in cycle n) gives PCF=PCTargetE in n+1.
- Load-use stall (StallF=StallD=FlushE=1 for one cycle):
  - PCF and IF/ID hold.
  - ID/EX becomes a bubble.
  - The held instruction enters E one cycle later.
- Reset asserted mid-stall or mid-flush: the reset values win. The first fetch after release is at RESET_PC.

## Test plan

- Reset and free run: rst 2 cycles, RESET_PC=0, no hazards -> PCF 0,4,8,12; InstrD lags InstrF by 1 cycle; validD=1 from the second cycle after reset; DdataSelE=2'b01 during reset.
- Load-use: StallF=StallD=FlushE=1 for one cycle at PCF=0x10 -> PCF stays 0x10 for 2 cycles; InstrD held; E outputs a bubble with validE=0, rdE=0, DdataSelE=01; stall_cnt=1.
- Branch redirect: PCSrcE=1, PCTargetE=0x100, FlushD=FlushE=1 at PCF=0x20 -> next PCF=0x100; InstrD=0x00000013, validD=0; validE=0; flush_cnt=1.
- Flush versus stall on IF/ID: StallD=1 and FlushD=1 together -> IF/ID takes the bubble; StallF=1 with PCSrcE=1 -> PCF held.
- Wrap and saturation: PCF=0xFFFFFFFC sequential -> 0x00000000; CNT_W=4 with StallF held 20 cycles -> stall_cnt=4'hF.
- Reset mid-stall: rst during a StallF run -> the next edge gives PCF=RESET_PC, counters 0, both stages bubbles.
